// File: rtl/bitrev_perm_ctrl_pkg.sv
// Shared constants and FSM state type for the 512-point NTT bit-reversal permutation sequencer.
package bitrev_perm_ctrl_pkg;

  localparam int unsigned N      = 512;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 14;
  localparam int unsigned Q      = 12289;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StRdA,
    StRdB,
    StCap,
    StWrA,
    StWrB,
    StDone
  } state_t;

endpackage

// File: rtl/bitrev_addr_gen.sv
// Combinational bit reversal of an index, used to find the swap partner of the current index.
module bitrev_addr_gen
  import bitrev_perm_ctrl_pkg::*;
#(
  parameter int unsigned Width = ADDR_W
) (
  input  logic [Width-1:0] idx,
  output logic [Width-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int unsigned k = 0; k < Width; k++) begin
      rev[k] = idx[Width-1-k];
    end
  end

endmodule

// File: rtl/bitrev_perm_ctrl.sv
// In-place bit-reversal permutation sequencer that owns the coefficient RAM port while busy.
// Optional swap counter output is enabled by defining BITREV_SWAP_CNT_EN.
module bitrev_perm_ctrl
  import bitrev_perm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BITREV_SWAP_CNT_EN
  ,
  output logic [ADDR_W-1:0] swap_cnt
`endif
);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   j;
  logic [ADDR_W-1:0]   j_rev;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;

  bitrev_addr_gen #(
    .Width(ADDR_W)
  ) u_addr_gen (
    .idx(idx),
    .rev(j_rev)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      idx      <= '0;
      j        <= '0;
      a        <= '0;
      b        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
`ifdef BITREV_SWAP_CNT_EN
      swap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StScan;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef BITREV_SWAP_CNT_EN
            swap_cnt <= '0;
`endif
          end
        end
        StScan: begin
          j <= j_rev;
          // Only the lower index of each pair performs the swap; palindromes are skipped.
          if (j_rev > idx) begin
            state    <= StRdA;
            mem_addr <= idx;
          end else if (idx == LAST_IDX) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        StRdA: begin
          state    <= StRdB;
          mem_addr <= j;
        end
        StRdB: begin
          state <= StCap;
          a     <= mem_rdata;
        end
        StCap: begin
          state    <= StWrA;
          b        <= mem_rdata;
          mem_addr <= idx;
        end
        StWrA: begin
          state    <= StWrB;
          mem_addr <= j;
        end
        StWrB: begin
`ifdef BITREV_SWAP_CNT_EN
          swap_cnt <= swap_cnt + ADDR_W'(1);
`endif
          if (idx == LAST_IDX) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= StScan;
            idx   <= idx + ADDR_W'(1);
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Write strobe and data are pure decodes of the state register, so they drop on reset at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      StWrA: begin
        mem_we    = 1'b1;
        mem_wdata = b;
      end
      StWrB: begin
        mem_we    = 1'b1;
        mem_wdata = a;
      end
      default: begin
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bitrev_perm_ctrl.sv
// Self-checking bench for bitrev_perm_ctrl: bench-owned RAM, arithmetic permutation model,
// per-cycle write checker. Exercises BITREV_SWAP_CNT_EN checks when that macro is defined.
module tb_bitrev_perm_ctrl;
  import bitrev_perm_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef BITREV_SWAP_CNT_EN
  logic [ADDR_W-1:0] swap_cnt;
`endif

  bitrev_perm_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef BITREV_SWAP_CNT_EN
    ,
    .swap_cnt (swap_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [DATA_W-1:0] ram [0:N-1];
  logic              preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < N; k++) ram[k] <= DATA_W'(k);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int model [N];
  int exp_addr [$];
  int exp_data [$];
  bit chk_en = 1'b0;
  int wr_cnt = 0;

  function automatic int brev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < int'(ADDR_W); b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected write stream of one pass, applied to the model contents.
  task automatic build_expect();
    int jj;
    int t;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < N; i++) begin
      jj = brev(i);
      if (jj > i) begin
        exp_addr.push_back(i);
        exp_data.push_back(model[jj]);
        exp_addr.push_back(jj);
        exp_data.push_back(model[i]);
        t         = model[i];
        model[i]  = model[jj];
        model[jj] = t;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (mem_we) begin
        wr_cnt++;
        check("palindrome_write", int'(brev(int'(mem_addr)) == int'(mem_addr)), 0);
        if (exp_addr.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("wr_addr", int'(mem_addr), exp_addr.pop_front());
          check("wr_data", int'(mem_wdata), exp_data.pop_front());
        end
      end else begin
        check("wdata_idle", int'(mem_wdata), 0);
      end
      if (done) check("busy_at_done", int'(busy), 0);
    end
  end

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int k = 0; k < N; k++) model[k] = k;
  endtask

  task automatic run_pass(input bit poke);
    int n;
    int busy_cyc;
    int busy_low;
    int extra;
    int bad;
    build_expect();
    wr_cnt = 0;
    chk_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = 1;
    busy_cyc = 0;
    busy_low = 0;
`ifdef BITREV_SWAP_CNT_EN
    check("swap_cnt_cleared", int'(swap_cnt), 0);
`endif
    while (!done && n < 3000) begin
      if (busy) busy_cyc++;
      else busy_low++;
      start = poke && (n == 10 || n == 500);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("done_latency", n, 1713);
    check("busy_cycles", busy_cyc, 1712);
    check("busy_glitch", busy_low, 0);
`ifdef BITREV_SWAP_CNT_EN
    check("swap_cnt_at_done", int'(swap_cnt), 240);
`endif
    @(posedge clk);
    #1;
    check("done_pulse_width", int'(done), 0);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check("no_requeued_pass", extra, 0);
`ifdef BITREV_SWAP_CNT_EN
    check("swap_cnt_holds", int'(swap_cnt), 240);
`endif
    chk_en = 1'b0;
    check("write_count", wr_cnt, 480);
    check("queue_drained", exp_addr.size(), 0);
    bad = 0;
    for (int k = 0; k < N; k++) if (int'(ram[k]) != model[k]) bad++;
    check("ram_vs_model", bad, 0);
  endtask

  task automatic reset_midpass();
    int n;
    do_preload();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
`ifdef BITREV_SWAP_CNT_EN
    check("rst_swap_cnt", int'(swap_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_we", int'(mem_we), 0);
    check("reset_addr", int'(mem_addr), 0);
    check("reset_wdata", int'(mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0;

    // Pin the model against hand-computed reversals.
    check("model_brev1", brev(1), 256);
    check("model_brev3", brev(3), 384);
    check("model_brev16", brev(16), 16);
    check("model_brev273", brev(273), 273);

    do_preload();
    run_pass(1'b0);
    check("ram1", int'(ram[1]), 256);
    check("ram256", int'(ram[256]), 1);
    check("ram3", int'(ram[3]), 384);
    check("ram0", int'(ram[0]), 0);

    // Second pass, with stray start pulses mid-pass, restores identity.
    run_pass(1'b1);
    bad = 0;
    for (int k = 0; k < N; k++) if (int'(ram[k]) != k) bad++;
    check("identity_after_two", bad, 0);

    reset_midpass();
    do_preload();
    run_pass(1'b0);
    check("restart_ram1", int'(ram[1]), 256);
    check("restart_ram3", int'(ram[3]), 384);
    check("restart_ram511", int'(ram[511]), 511);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
